// File: rtl/fir_data_ring_ctrl_pkg.sv
// Shared types and ring-pointer helpers for the FIR sample-history RAM controller.
package fir_data_ring_ctrl_pkg;

  localparam int NTAP_DEF       = 11;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int BIT_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READ  = 2'd2
  } state_t;

  function automatic int ring_inc(input int a, input int n);
    return (a == n - 1) ? 0 : a + 1;
  endfunction

  // (a - b) mod n for 0 <= a < n, 0 <= b <= n
  function automatic int ring_sub(input int a, input int b, input int n);
    return (a >= b) ? a - b : a + n - b;
  endfunction

endpackage

// File: rtl/fir_data_ring_ctrl.sv
// Writes one sample per handshake into a circular BRAM buffer, then streams the
// whole tap window newest-to-oldest to the MAC; zero-fills the RAM after reset.
module fir_data_ring_ctrl
  import fir_data_ring_ctrl_pkg::*;
#(
  parameter int NTAP       = NTAP_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BIT_WIDTH-1:0]  s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BIT_WIDTH-1:0]  m_data,
  output logic [3:0]            m_idx,
  output logic                  m_last,
  output logic                  busy,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [BIT_WIDTH-1:0]  bram_wdi,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [BIT_WIDTH-1:0]  bram_rdo
);

  localparam int PW = $clog2(NTAP);

  state_t        r_state, w_state_nx;
  logic [PW-1:0] r_wptr, r_base, r_clr_cnt;
  logic [PW:0]   r_k;
  logic          r_m_valid, r_m_last;
  logic [3:0]    r_m_idx;

  logic          w_accept, w_issue, w_clr_done;
  logic [PW-1:0] w_waddr_p, w_raddr_p;

  assign w_clr_done = (r_clr_cnt == PW'(NTAP - 1));
  assign w_raddr_p  = PW'(ring_sub(int'(r_base), int'(r_k), NTAP));

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_issue    = 1'b0;
    w_waddr_p  = '0;
    bram_we    = 1'b0;
    bram_wdi   = '0;
    bram_re    = 1'b0;
    s_ready    = 1'b0;
    // all strobes are held off while reset is asserted
    if (!rst) begin
      unique case (r_state)
        CLEAR: begin
          bram_we   = 1'b1;
          w_waddr_p = r_clr_cnt;
          if (w_clr_done) w_state_nx = IDLE;
        end
        IDLE: begin
          s_ready = !clear;
          if (clear) begin
            w_state_nx = CLEAR;
          end else if (s_valid) begin
            w_accept   = 1'b1;
            bram_we    = 1'b1;
            w_waddr_p  = r_wptr;
            bram_wdi   = s_data;
            w_state_nx = READ;
          end
        end
        READ: begin
          w_issue = (r_k < (PW+1)'(NTAP)) && (!r_m_valid || m_ready);
          bram_re = w_issue;
          if (r_m_valid && m_ready && r_m_last) w_state_nx = IDLE;
        end
        default: w_state_nx = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_wptr    <= '0;
      r_base    <= '0;
      r_clr_cnt <= '0;
      r_k       <= '0;
      r_m_valid <= 1'b0;
      r_m_idx   <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == CLEAR) begin
        r_clr_cnt <= w_clr_done ? '0 : r_clr_cnt + 1'b1;
        if (w_clr_done) r_wptr <= '0;
      end
      if (w_accept) begin
        r_base <= r_wptr;
        r_wptr <= PW'(ring_inc(int'(r_wptr), NTAP));
        r_k    <= '0;
      end
      // a stalled tap keeps m_valid; bram_rdo holds since no read is issued
      r_m_valid <= w_issue | (r_m_valid & ~m_ready);
      if (w_issue) begin
        r_k      <= r_k + 1'b1;
        r_m_idx  <= 4'(r_k);
        r_m_last <= (r_k == (PW+1)'(NTAP - 1));
      end
    end
  end

  assign bram_waddr = ADDR_WIDTH'(w_waddr_p);
  assign bram_raddr = ADDR_WIDTH'(w_raddr_p);
  assign m_valid    = r_m_valid;
  assign m_data     = bram_rdo;
  assign m_idx      = r_m_idx;
  assign m_last     = r_m_last;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fir_data_ring_ctrl.sv
// Bench for fir_data_ring_ctrl: behavioural BRAM plus a sample-history queue model.
module tb_fir_data_ring_ctrl;

  localparam int NTAP = 11;
  localparam int AW   = 12;
  localparam int BW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [BW-1:0] m_data;
  logic [3:0]    m_idx;
  logic          m_last;
  logic          busy;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [BW-1:0] bram_wdi;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [BW-1:0] bram_rdo = '0;

  always #5 clk = ~clk;

  fir_data_ring_ctrl dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .busy(busy),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdi(bram_wdi),
    .bram_re(bram_re), .bram_raddr(bram_raddr), .bram_rdo(bram_rdo)
  );

  // 1-cycle registered-read BRAM; output holds while re is low
  logic [BW-1:0] mem [0:15];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (bram_we) mem[bram_waddr[3:0]] <= bram_wdi;
    if (bram_re) bram_rdo <= mem[bram_raddr[3:0]];
  end

  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] hist[$];   // hist[k] = sample k positions older than newest
  int wptr_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NTAP; i++) hist.push_back('0);
    wptr_m = 0;
  endtask

  // entry: first CLEAR cycle, before outputs are sampled
  task automatic check_clear();
    for (int i = 0; i < NTAP; i++) begin
      #1;
      chk("clr_we", bram_we, 1);
      chk("clr_waddr", bram_waddr, i);
      chk("clr_wdi", bram_wdi, 0);
      chk("clr_busy", busy, 1);
      @(negedge clk);
    end
    #1;
    chk("post_clr_busy", busy, 0);
    chk("post_clr_srdy", s_ready, 1);
    chk("post_clr_we", bram_we, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1; s_valid = 1'b1; s_data = 32'd99;
    #1;
    chk("clrreq_srdy", s_ready, 0);
    chk("clrreq_we", bram_we, 0);
    @(negedge clk);
    clear = 1'b0; s_valid = 1'b0;
    model_reset();
    check_clear();
  endtask

  // mode 0: m_ready=1, 1: toggling, 2: random. rst_at>=0 resets while that tap shows.
  task automatic run_window(input logic [BW-1:0] d, input int mode, input int rst_at);
    int base, k, iss, cyc;
    logic [BW-1:0] held;
    logic stalled;
    s_valid = 1'b1; s_data = d;
    #1;
    chk("acc_srdy", s_ready, 1);
    chk("acc_we", bram_we, 1);
    chk("acc_waddr", bram_waddr, wptr_m);
    chk("acc_wdi", bram_wdi, d);
    base = wptr_m;
    hist.push_front(d);
    void'(hist.pop_back());
    wptr_m = (wptr_m + 1) % NTAP;
    @(negedge clk);
    s_valid = 1'b0;
    k = 0; iss = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k < NTAP && cyc < 100) begin
      cyc++;
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      #1;
      if (rst_at >= 0 && m_valid && k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mvalid", m_valid, 0);
        chk("rst_busy", busy, 1);
        model_reset();
        m_ready = 1'b1;
        check_clear();
        return;
      end
      if (mode == 0 && cyc == 1) begin
        chk("lat_mvalid0", m_valid, 0);
        chk("lat_re0", bram_re, 1);
      end
      if (mode == 0 && cyc == 2) chk("lat_mvalid1", m_valid, 1);
      if (bram_re) begin
        chk("raddr", bram_raddr, (base + NTAP - iss) % NTAP);
        iss++;
      end
      if (m_valid) begin
        if (stalled) chk("stall_data", m_data, held);
        if (!m_ready) chk("stall_re", bram_re, 0);
        if (m_ready) begin
          chk("tap_data", m_data, hist[k]);
          chk("tap_idx", m_idx, k);
          chk("tap_last", m_last, (k == NTAP - 1));
          k++;
        end
        stalled = !m_ready;
        held = m_data;
      end
      @(negedge clk);
    end
    if (k < NTAP) chk("timeout_taps", k, NTAP);
    if (mode == 0) chk("win_len", cyc, NTAP + 1);
    #1;
    chk("win_issues", iss, NTAP);
    chk("win_idle", busy, 0);
    chk("win_mvalid", m_valid, 0);
    m_ready = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_we", bram_we, 0);
    chk("rst_re", bram_re, 0);
    chk("rst_srdy", s_ready, 0);
    chk("rst_mv", m_valid, 0);
    rst = 1'b0;
    check_clear();

    run_window(32'd5, 0, -1);
    do_clear();
    for (int i = 1; i <= 14; i++)
      run_window(BW'(i), (i == 14) ? 0 : (i % 2 == 1) ? 1 : 2, -1);
    for (int i = 0; i < 6; i++) run_window($urandom, 2, -1);
    do_clear();
    run_window(32'd7, 0, -1);
    run_window(32'd8, 1, 4);
    run_window(32'd3, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_data_ring_ctrl.md
Name: fir_data_ring_ctrl

Overview:
Initiator-side controller for an 11-entry, 32-bit simple dual-port BRAM with a 1-cycle registered read and read-enable gating, used as the FIR data (sample history) RAM. It accepts one input sample per handshake and writes it into a circular buffer. It then streams the full tap window, newest to oldest, to the downstream MAC through a valid/ready interface. It also zero-fills the RAM after reset and on request.

Parameters:
NTAP, 11, number of buffer entries and taps per window
ADDR_WIDTH, 12, BRAM address width; upper bits beyond the pointer are driven 0
BIT_WIDTH, 32, sample width

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
clear  in  1  zero-fill request; sampled only in IDLE
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid & s_ready
s_data  in  BIT_WIDTH  input sample
m_valid  out  1  window tap valid
m_ready  in  1  downstream accepts tap
m_data  out  BIT_WIDTH  tap sample; equals bram_rdo
m_idx  out  4  tap index k (0 = newest)
m_last  out  1  high with k = NTAP-1
busy  out  1  high in any state other than IDLE
bram_we  out  1  BRAM write enable
bram_waddr  out  ADDR_WIDTH  BRAM write address
bram_wdi  out  BIT_WIDTH  BRAM write data
bram_re  out  1  BRAM read enable
bram_raddr  out  ADDR_WIDTH  BRAM read address
bram_rdo  in  BIT_WIDTH  BRAM read data; valid 1 cycle after bram_re, held while bram_re is low

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=CLEAR, wptr=0, clr_cnt=0, k=0, m_valid=0. bram_we/bram_re/s_ready are 0 on the first cycle after reset.
- States:
  - CLEAR: writes 0 to addresses 0..NTAP-1, one per cycle (bram_we=1, waddr=clr_cnt, wdi=0). Takes exactly NTAP cycles, then sets wptr=0 and moves to IDLE.
  - IDLE: s_ready=1 unless clear=1. clear=1 has priority over s_valid: go to CLEAR and accept no sample that cycle.
    - On an accept: bram_we=1, waddr=wptr, wdi=s_data, combinationally in the accept cycle. Latch base=wptr, advance wptr to (wptr==NTAP-1 ? 0 : wptr+1), set k=0, go to READ.
  - READ: issue bram_re=1 with raddr=(base-k) mod NTAP whenever k_issue<NTAP and (!m_valid | m_ready).
    - m_valid next = issued | (m_valid & ~m_ready).
    - m_idx/m_last are registered alongside the issue.
    - When the m_last tap is consumed (m_valid & m_ready & m_last), go to IDLE.
- Throughput: 1 tap/cycle with m_ready held high. First m_valid appears 2 cycles after the accept edge. A window takes NTAP cycles plus 1 latency.
- Backpressure: no read is issued while a tap is stalled. bram_rdo holds because re=0, so m_data stays stable while m_valid & ~m_ready.
- Hazard: the write commits on the accept edge, before any read of that window, so no read-during-write occurs.
- Wrap-around: modulo subtraction, e.g. base=2 reads 2,1,0,10,9,…,3.
- Protocol rules:
  - s_ready is 0 outside IDLE.
  - clear asserted outside IDLE is ignored and not latched.
  - rst mid-window drops all output; m_valid goes 0 on the next cycle and CLEAR restarts.

Decomposition:
- Shared package holds: state enum {IDLE, CLEAR, READ}, the NTAP/ADDR_WIDTH/BIT_WIDTH defaults, and a modulo-NTAP decrement/increment function.
- No sub-module; the block is a single FSM with counters.
- bram11 is instantiated only in the testbench and in the parent.

Test Plan:
- Reset, then hold s_valid=0 -> bram_we=1 for exactly 11 cycles with waddrs 0..10, wdi=0; then busy=0 and s_ready=1.
- Feed sample 5 with m_ready=1 -> 11 taps with m_idx 0..10, data 5,0,0,…,0; m_last only on idx 10; window lasts 12 cycles from accept.
- Feed samples 1..14 -> for sample 14 (written at addr 2), the raddr sequence is 2,1,0,10,…,3 and the data is 14,13,…,4.
- Toggle m_ready 0/1 every cycle during a window -> m_data stays stable while stalled, no tap is dropped or duplicated, and bram_re is 0 in stall cycles.
- Assert clear and s_valid together in IDLE -> no sample is written, CLEAR runs 11 cycles, and the next window after sample 7 reads 7,0,…,0.
- Assert rst at tap 4 of a window -> m_valid=0 next cycle, followed by an 11-cycle CLEAR with wptr=0.
